result_accumulator: RTL and testbench
=====================================

Name: result_accumulator

Overview:
Downstream consumer of the 64-bit operation-unit result stream (z). Sums groups of up to COUNT results into a wider accumulator and emits one sum per group. Uses valid/ready on both sides and holds output under backpressure. Sits between the operation unit and the result writeback/reporting logic.

Parameters:
DATA_W, 64, input sample width; samples are two's-complement signed.
ACC_W, 72, accumulator and output width; must satisfy ACC_W >= DATA_W + $clog2(COUNT), otherwise elaboration error via $error.
COUNT, 4, maximum samples per group; must be >= 1, otherwise elaboration error.
CNT_W (localparam), $clog2(COUNT+1), width of out_count.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data and in_last are valid.
in_ready  output  1  block accepts a sample this cycle.
in_data  input  DATA_W  signed sample (operation-unit z).
in_last  input  1  with a handshake, closes the group after this sample.
out_valid  output  1  out_data and out_count are valid.
out_ready  input  1  downstream accepts the output.
out_data  output  ACC_W  signed group sum.
out_count  output  CNT_W  number of samples in the group, 1..COUNT.

Behaviour:
- Reset, one cycle with rst high, takes effect at the next edge:
  - state=ACCUM, cnt=0, acc=0.
  - out_valid=0, out_data=0, out_count=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- Reset mid-group or with an output pending discards the partial sum and the pending output. No output is produced for the discarded group.
- Input handshake: in_valid && in_ready at a rising edge. An input transfer means this handshake.
- State ACCUM (in_ready=1, out_valid=0):
  - On an input transfer: acc <= (cnt==0 ? 0 : acc) + sign_extend(in_data, ACC_W), and cnt <= cnt+1.
  - If the transfer has in_last=1 or cnt==COUNT-1:
    - Go to OUT.
    - out_data <= the new sum, out_count <= cnt+1, out_valid <= 1.
    - cnt <= 0.
  - No transfer: all state holds.
- State OUT (in_ready=0, out_valid=1):
  - out_data and out_count are held stable until the output handshake (out_valid && out_ready).
  - On the output handshake: go to ACCUM, out_valid <= 0. out_data and out_count keep their last values; they are don't-care while out_valid=0.
  - in_valid is ignored; no input sample is consumed.
- Latency: out_valid rises on the edge that accepts the last sample of a group.
- Throughput: one group per (group samples + 1) cycles minimum. There is no same-cycle bypass from OUT to accepting an input.
- in_ready is a function of state and rst only, registered-state driven. It has no combinational path from out_ready or in_valid.
- Arithmetic:
  - Sign extension is mandatory, so 64'hFFFF_FFFF_FFFF_FFFF counts as -1.
  - The ACC_W rule guarantees no overflow; no saturation logic.
- in_last with COUNT==1 is redundant; every sample closes its group.
- in_data and in_last are sampled only on an input transfer. Their values without a transfer have no effect.

Test Plan:
- Basic group: COUNT=4, samples 1,2,3,4 back-to-back, out_ready=1 -> one output out_data=10, out_count=4, out_valid high 1 cycle; in_ready low exactly that cycle.
- Sign extension: four samples of 64'hFFFF_FFFF_FFFF_FFFF -> out_data=72'hFF_FFFF_FFFF_FFFF_FFFC (-4), out_count=4.
- Max positive: four samples of 64'h7FFF_FFFF_FFFF_FFFF -> out_data=72'h01_FFFF_FFFF_FFFF_FFFC, no wrap.
- Early close: samples 5 then 7 with in_last=1 on 7 -> out_data=12, out_count=2. Next group 1,1,1,1 -> out_data=4, showing no carry-over of the previous sum.
- Backpressure: complete group 1,2,3,4, hold out_ready=0 for 3 cycles with in_valid=1 and in_data=9 -> out_data stays 10, out_valid stays 1, in_ready=0, no sample consumed. Raise out_ready -> handshake; the next accepted sample is 9.
- Reset mid-group and mid-output:
  - Accept 100 and 200, assert rst one cycle, then send 1,1,1,1 -> out_data=4.
  - Separately, assert rst while out_valid=1 -> out_valid=0 next cycle, in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/result_accumulator_if.sv
// result_accumulator_if: valid/ready sample input and group-sum output bundle
interface result_accumulator_if #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 72,
  parameter int COUNT  = 4
);
  localparam int CNT_W = $clog2(COUNT + 1);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/result_accumulator.sv
// result_accumulator: sums groups of up to COUNT signed samples, one sum per group
module result_accumulator #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 72,
  parameter int COUNT  = 4
) (
  input logic clk,
  input logic rst,
  result_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(COUNT + 1);
  if (COUNT < 1) begin : g_bad_count
    $error("result_accumulator: COUNT must be >= 1");
  end
  if (ACC_W < DATA_W + $clog2(COUNT)) begin : g_bad_acc
    $error("result_accumulator: ACC_W too narrow for DATA_W and COUNT");
  end
  typedef enum logic {ACCUM, OUT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, out_count;
  logic [ACC_W-1:0] acc, sum, out_data;
  logic in_fire, out_fire, close;
  assign bus.in_ready  = (state == ACCUM) && !rst;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_data;
  assign bus.out_count = out_count;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign close    = in_fire && (bus.in_last || cnt == CNT_W'(COUNT - 1));
  // first sample of a group starts from zero so stale acc never leaks in
  assign sum = (cnt == '0 ? '0 : acc) + ACC_W'($signed(bus.in_data));
  always_comb begin
    state_n = state;
    if (state == ACCUM && close) state_n = OUT;
    if (state == OUT && out_fire) state_n = ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      state <= state_n;
      if (in_fire) begin
        acc <= sum;
        cnt <= close ? '0 : cnt + 1'b1;
      end
      if (close) begin
        out_data  <= sum;
        out_count <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: table-driven directed checks plus reset corner sequences
module tb_result_accumulator;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int errors = 0;
  result_accumulator_if #(.DATA_W(64), .ACC_W(72), .COUNT(4)) bus ();
  result_accumulator #(.DATA_W(64), .ACC_W(72), .COUNT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        last;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [71:0] e_data;
    logic [2:0]  e_cnt;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic v, input logic [63:0] d, input logic last, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [71:0] e_data, input logic [2:0] e_cnt);
    tbl.push_back('{v, d, last, ordy, e_ir, e_ov, e_data, e_cnt});
  endtask
  task automatic drive(input logic v, input logic [63:0] d, input logic last, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask
  task automatic group4(input logic [63:0] d, input logic ordy);
    for (int i = 0; i < 4; i++) drive(1, d, 0, ordy);
  endtask
  initial begin
    rst = 1;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
    #1;
    chk("rst_in_ready_low", 72'(bus.in_ready), 72'd0);
    @(posedge clk); #1;
    chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("rst_out_data", bus.out_data, 72'd0);
    chk("rst_out_count", 72'(bus.out_count), 72'd0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", 72'(bus.in_ready), 72'd1);
    // basic group 1..4
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 2, 0, 1, 1, 0, 0, 0);
    add(0, 64'd123, 1, 1, 1, 0, 0, 0);
    add(1, 3, 0, 1, 1, 0, 0, 0);
    add(1, 4, 0, 1, 0, 1, 72'd10, 3'd4);
    add(1, 77, 0, 1, 1, 0, 0, 0);
    // sign extension
    add(1, '1, 0, 1, 1, 0, 0, 0);
    add(1, '1, 0, 1, 1, 0, 0, 0);
    add(1, '1, 0, 1, 1, 0, 0, 0);
    add(1, '1, 0, 1, 0, 1, 72'hFF_FFFF_FFFF_FFFF_FFFC, 3'd4);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    // max positive
    add(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 0, 0);
    add(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 0, 0);
    add(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 0, 0);
    add(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0, 1, 72'h01_FFFF_FFFF_FFFF_FFFC, 3'd4);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    // early close then fresh group
    add(1, 5, 0, 1, 1, 0, 0, 0);
    add(1, 7, 1, 1, 0, 1, 72'd12, 3'd2);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 72'd4, 3'd4);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    // backpressure: held output, input ignored, then 9 is next accepted sample
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 2, 0, 0, 1, 0, 0, 0);
    add(1, 3, 0, 0, 1, 0, 0, 0);
    add(1, 4, 0, 0, 0, 1, 72'd10, 3'd4);
    add(1, 9, 0, 0, 0, 1, 72'd10, 3'd4);
    add(1, 9, 0, 0, 0, 1, 72'd10, 3'd4);
    add(1, 9, 0, 0, 0, 1, 72'd10, 3'd4);
    add(1, 9, 0, 1, 1, 0, 0, 0);
    add(1, 9, 1, 1, 0, 1, 72'd9, 3'd1);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 72'(bus.in_ready), 72'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 72'(bus.out_valid), 72'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), bus.out_data, tbl[i].e_data);
        chk($sformatf("vec%0d_out_count", i), 72'(bus.out_count), 72'(tbl[i].e_cnt));
      end
    end
    // reset mid-group discards partial sum
    drive(1, 100, 0, 1);
    drive(1, 200, 0, 1);
    rst = 1;
    drive(0, 0, 0, 1);
    chk("midgrp_rst_out_valid", 72'(bus.out_valid), 72'd0);
    rst = 0;
    group4(1, 1);
    chk("midgrp_out_valid", 72'(bus.out_valid), 72'd1);
    chk("midgrp_out_data", bus.out_data, 72'd4);
    chk("midgrp_out_count", 72'(bus.out_count), 72'd4);
    drive(0, 0, 0, 1);
    // reset with output pending
    group4(3, 0);
    chk("pend_out_valid", 72'(bus.out_valid), 72'd1);
    chk("pend_out_data", bus.out_data, 72'd12);
    rst = 1;
    drive(0, 0, 0, 0);
    chk("pend_rst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("pend_rst_in_ready", 72'(bus.in_ready), 72'd0);
    rst = 0;
    #1;
    chk("pend_post_rst_in_ready", 72'(bus.in_ready), 72'd1);
    drive(1, 6, 1, 1);
    chk("pend_next_out_data", bus.out_data, 72'd6);
    chk("pend_next_out_count", 72'(bus.out_count), 72'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
